ps2_scan_decoder: RTL

PS2_SCAN_DECODER -- requirements
Module: ps2_scan_decoder

---
 rtl/ps2_scan_decoder.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/ps2_scan_decoder.sv
// PS/2 keyboard scan-code decoder: synchronise, deglitch, frame, and turn make codes into key strobes.
// Optional build macro TYPEMATIC_FILTER_EN suppresses typematic repeats of the held key.
module ps2_scan_decoder #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int STROBE_CYCLES  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       key_strobe,
    output logic [7:0] key_code,
    output logic       key_extended,
    output logic       frame_err
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int SW = $clog2(STROBE_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [1:0]    clk_s_q, dat_s_q;
    logic          filt_q, filt_d, fprev_q;
    logic [FW-1:0] fcnt_q, fcnt_d;
    state_t        state_q, state_d;
    logic [2:0]    bcnt_q, bcnt_d;
    logic [7:0]    shr_q, shr_d;
    logic          par_q, par_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          ext_q, ext_d, brk_q, brk_d;
    logic [7:0]    code_q, code_d;
    logic          kext_q, kext_d;
    logic          err_q, err_d;
    logic [SW-1:0] scnt_q, scnt_d;
    logic          fall, dat;
`ifdef TYPEMATIC_FILTER_EN
    logic [8:0]    held_q, held_d;
    logic          hvld_q, hvld_d;
`endif

    assign dat          = dat_s_q[1];
    assign fall         = fprev_q & ~filt_q;
    assign key_strobe   = (scnt_q != '0);
    assign key_code     = code_q;
    assign key_extended = kext_q;
    assign frame_err    = err_q;

    // Filtered level flips only after FILTER_LEN consecutive disagreeing samples.
    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        if (clk_s_q[1] != filt_q) begin
            if (fcnt_q == FW'(FILTER_LEN - 1)) filt_d = ~filt_q;
            else fcnt_d = fcnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        shr_d   = shr_q;
        par_d   = par_q;
        ext_d   = ext_q;
        brk_d   = brk_q;
        code_d  = code_q;
        kext_d  = kext_q;
        err_d   = 1'b0;
        scnt_d  = (scnt_q != '0) ? scnt_q - 1'b1 : scnt_q;
`ifdef TYPEMATIC_FILTER_EN
        held_d  = held_q;
        hvld_d  = hvld_q;
`endif
        if (state_q == IDLE || fall) tcnt_d = '0;
        else                         tcnt_d = tcnt_q + 1'b1;

        if (fall) begin
            case (state_q)
                IDLE: if (!dat) begin
                    state_d = DATA;
                    bcnt_d  = '0;
                end
                DATA: begin
                    shr_d  = {dat, shr_q[7:1]};
                    bcnt_d = bcnt_q + 1'b1;
                    if (bcnt_q == 3'd7) state_d = PARITY;
                end
                PARITY: begin
                    par_d   = dat;
                    state_d = STOP;
                end
                default: begin
                    state_d = IDLE;
                    if (!dat || !(^{shr_q, par_q})) begin
                        err_d = 1'b1;
                        ext_d = 1'b0;
                        brk_d = 1'b0;
                    end else if (shr_q == 8'hE0) begin
                        ext_d = 1'b1;
                    end else if (shr_q == 8'hF0) begin
                        brk_d = 1'b1;
                    end else if (brk_q) begin
                        ext_d = 1'b0;
                        brk_d = 1'b0;
`ifdef TYPEMATIC_FILTER_EN
                        if (hvld_q && held_q == {ext_q, shr_q}) hvld_d = 1'b0;
`endif
                    end else begin
                        ext_d = 1'b0;
                        brk_d = 1'b0;
`ifdef TYPEMATIC_FILTER_EN
                        if (!(hvld_q && held_q == {ext_q, shr_q})) begin
                            code_d = shr_q;
                            kext_d = ext_q;
                            scnt_d = SW'(STROBE_CYCLES);
                            held_d = {ext_q, shr_q};
                            hvld_d = 1'b1;
                        end
`else
                        code_d = shr_q;
                        kext_d = ext_q;
                        scnt_d = SW'(STROBE_CYCLES);
`endif
                    end
                end
            endcase
        end else if (state_q != IDLE && tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
            state_d = IDLE;
            err_d   = 1'b1;
            ext_d   = 1'b0;
            brk_d   = 1'b0;
            tcnt_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_s_q <= 2'b11;
            dat_s_q <= 2'b11;
            filt_q  <= 1'b1;
            fprev_q <= 1'b1;
            fcnt_q  <= '0;
            state_q <= IDLE;
            bcnt_q  <= '0;
            shr_q   <= '0;
            par_q   <= 1'b0;
            tcnt_q  <= '0;
            ext_q   <= 1'b0;
            brk_q   <= 1'b0;
            code_q  <= '0;
            kext_q  <= 1'b0;
            err_q   <= 1'b0;
            scnt_q  <= '0;
`ifdef TYPEMATIC_FILTER_EN
            held_q  <= '0;
            hvld_q  <= 1'b0;
`endif
        end else begin
            clk_s_q <= {clk_s_q[0], ps2_clk};
            dat_s_q <= {dat_s_q[0], ps2_data};
            filt_q  <= filt_d;
            fprev_q <= filt_q;
            fcnt_q  <= fcnt_d;
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            shr_q   <= shr_d;
            par_q   <= par_d;
            tcnt_q  <= tcnt_d;
            ext_q   <= ext_d;
            brk_q   <= brk_d;
            code_q  <= code_d;
            kext_q  <= kext_d;
            err_q   <= err_d;
            scnt_q  <= scnt_d;
`ifdef TYPEMATIC_FILTER_EN
            held_q  <= held_d;
            hvld_q  <= hvld_d;
`endif
        end
    end
endmodule
